fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the 16-bit pipeline. It owns the program counter and drives the combinational instruction memory's 8-bit address. It captures the returned word into the IF/ID pipeline register. It sequences stalls from the hazard unit, redirects from the execute stage, halt, and an optional early-jump predecode.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- NOP_WORD, 16'h0000, word loaded into IF/ID on a bubble

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  ADDR_W  address to instruction memory (= pc, combinational)
- imem_data  in  INSTR_W  instruction word at imem_addr, same cycle
- stall_i  in  1  hazard unit: hold pc and IF/ID
- redirect_i  in  1  execute stage resolved a jump; load redirect_pc_i
- redirect_pc_i  in  ADDR_W  jump target
- halt_i  in  1  stop fetching; exit only by reset
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc  out  ADDR_W  IF/ID instruction address
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pred_taken  out  1  IF/ID jump was already taken by predecode
- flush_idex_o  out  1  squash ID/EX this cycle (= redirect_i & state≠HALT)
- state_o  out  2  current FSM state
- bubble_cnt  out  16  saturating count of cycles IF/ID loaded a bubble

## Operation
- FSM states: RUN=0, STALL=1, HALT=2. Reset state is RUN.
- Reset values: pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0, ifid_pred_taken=0, bubble_cnt=0.
- Per-edge priority, highest first: halt_i > redirect_i > stall_i > normal fetch.
- **halt_i**
  - Go to HALT; pc frozen; IF/ID ← bubble (valid 0).
  - HALT ignores stall_i and redirect_i. flush_idex_o is 0.
  - Only rst_n leaves HALT.
- **redirect_i** (RUN or STALL)
  - pc ← redirect_pc_i; IF/ID ← bubble; next state RUN.
  - flush_idex_o=1 in the same cycle.
  - A redirect overrides a concurrent stall.
- **stall_i** (no redirect)
  - pc and IF/ID held; state STALL.
  - Leaving STALL when stall_i drops resumes normal fetch with no lost or duplicated instruction.
- **Normal fetch**
  - IF/ID ← {imem_data, pc, valid=1}; pc ← pc+1 modulo 2^ADDR_W (255 wraps to 0); state RUN.
- **bubble_cnt**
  - +1 on each edge that loads a bubble. Stall holds are not counted.
  - Saturates at 16'hFFFF.
- **Jump encoding:** opcode imem_data[15:11]=5'b10101, target imem_data[7:0].

## Timing
- Fetch latency: 1 cycle. The word at pc during cycle n is in IF/ID after edge n.
- First valid IF/ID: after the first edge following rst_n release (ifid_pc=RESET_PC).
- Redirect at cycle n:
  - Edge n: pc=target, IF/ID bubble.
  - Edge n+1: target instruction is valid in IF/ID.
  - Two wrong-path instructions are removed: IF/ID here, ID/EX via flush_idex_o.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), including out of HALT and STALL.
- stall_i and redirect_i are sampled only at rising edges. Glitches between edges have no effect.

## Configuration
- FETCH_PREDECODE_EN defined:
  - In RUN with no halt, redirect or stall, a jump word at imem_data sets pc ← imem_data[7:0] instead of pc+1.
  - IF/ID gets the jump with ifid_pred_taken=1. The downstream stage must not assert redirect_i for it.
  - No bubble is counted.
- Undefined:
  - ifid_pred_taken tied 0.
  - Jumps are handled only via redirect_i.

## Structure
- Shared package fetch_pkg: FSM state enum (RUN/STALL/HALT), OPC_JUMP=5'b10101, NOP_WORD default, ADDR_W/INSTR_W defaults.
- One sub-module, jump_predecode: combinational opcode match and target extraction. It is instantiated only under FETCH_PREDECODE_EN.

## Test plan
- **Reset then free-run:** rst_n low, then high.
  - Edge 1: ifid_pc=0, valid=1.
  - Edge 3: ifid_pc=2.
  - imem_addr=3 after edge 3.
  - bubble_cnt=0.
- **Stall:** stall_i high for 3 cycles at pc=4.
  - pc stays 4 and IF/ID is unchanged; state_o=1.
  - After release, the next IF/ID has ifid_pc=4 with no duplication.
- **Redirect:** redirect_i with redirect_pc_i=10, concurrent with stall_i.
  - flush_idex_o=1; next ifid_valid=0, bubble_cnt=1.
  - Following edge: ifid_pc=10.
- **Wrap:** pc=255 with normal fetch → ifid_pc=255, then pc=0.
- **Halt:** halt_i for one cycle, then redirect_i.
  - state_o=2, ifid_valid=0, pc frozen, flush_idex_o=0.
  - rst_n pulse returns pc=0, state RUN.
- **Predecode (macro on):** word 16'b10101_000_00001010 at pc=4.
  - Next: ifid_pred_taken=1, pc=10, bubble_cnt unchanged.
  - With the macro off: pc=5, ifid_pred_taken=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch controller.
//   fetch_state_e  - fetch FSM state encoding (StRun/StStall/StHalt)
//   OPC_JUMP       - 5-bit opcode of the jump instruction (word bits [15:11])
//   *_DEF          - default widths and bubble word used by fetch_sequencer
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned INSTR_W_DEF  = 16;
    localparam logic [15:0] NOP_WORD_DEF = 16'h0000;
    localparam logic [4:0]  OPC_JUMP     = 5'b10101;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StHalt  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/jump_predecode.sv
// jump_predecode: combinational recognition of a jump word.
//   instr_i   - instruction word from instruction memory
//   is_jump_o - opcode field (top 5 bits) equals OPC_JUMP
//   target_o  - jump target, the low ADDR_W bits of the word
module jump_predecode
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic               is_jump_o,
    output logic [ADDR_W-1:0]  target_o
);

    assign is_jump_o = (instr_i[INSTR_W-1 -: 5] == OPC_JUMP);
    assign target_o  = instr_i[ADDR_W-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 16-bit pipeline.
// Owns the PC, addresses the combinational instruction memory and loads the
// IF/ID register. Edge priority: halt > redirect > stall > normal fetch.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   imem_addr/imem_data - instruction memory address (= pc) and returned word
//   stall_i             - hold pc and IF/ID
//   redirect_i/_pc_i    - execute-stage jump resolution and its target
//   halt_i              - stop fetching until reset
//   ifid_*              - IF/ID instruction, address, valid, predecode-taken flag
//   flush_idex_o        - squash ID/EX this cycle
//   state_o             - current FSM state (0 RUN, 1 STALL, 2 HALT)
//   bubble_cnt          - saturating count of bubbles loaded into IF/ID
// Build option: define FETCH_PREDECODE_EN to follow jump words in the fetch
// stage (pc <- target, ifid_pred_taken=1); otherwise ifid_pred_taken is 0.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               halt_i,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               ifid_pred_taken,
    output logic               flush_idex_o,
    output logic [1:0]         state_o,
    output logic [15:0]        bubble_cnt
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               ifid_pred_q, ifid_pred_d;
    logic [15:0]        bubble_cnt_q, bubble_cnt_d;
    logic               load_bubble;
    logic               pred_jump;
    logic [ADDR_W-1:0]  pred_target;

`ifdef FETCH_PREDECODE_EN
    logic is_jump;

    jump_predecode #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_jump_predecode (
        .instr_i   (imem_data),
        .is_jump_o (is_jump),
        .target_o  (pred_target)
    );

    // Only taken on a plain fetch in RUN; the redirect/stall/halt paths
    // below already take precedence in the next-state chain.
    assign pred_jump = is_jump && (state_q == StRun);
`else
    assign pred_jump   = 1'b0;
    assign pred_target = '0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pred_d  = ifid_pred_q;
        bubble_cnt_d = bubble_cnt_q;
        load_bubble  = 1'b0;

        if (state_q == StHalt) begin
            // Frozen until reset; stall and redirect are ignored.
        end else if (halt_i) begin
            state_d     = StHalt;
            load_bubble = 1'b1;
        end else if (redirect_i) begin
            state_d     = StRun;
            pc_d        = redirect_pc_i;
            load_bubble = 1'b1;
        end else if (stall_i) begin
            state_d = StStall;
        end else begin
            state_d      = StRun;
            ifid_instr_d = imem_data;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            ifid_pred_d  = pred_jump;
            pc_d         = pred_jump ? pred_target : pc_q + ADDR_W'(1);
        end

        if (load_bubble) begin
            ifid_instr_d = NOP_WORD;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b0;
            ifid_pred_d  = 1'b0;
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pred_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pred_q  <= ifid_pred_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign imem_addr       = pc_q;
    assign ifid_instr      = ifid_instr_q;
    assign ifid_pc         = ifid_pc_q;
    assign ifid_valid      = ifid_valid_q;
    assign ifid_pred_taken = ifid_pred_q;
    assign flush_idex_o    = redirect_i && (state_q != StHalt);
    assign state_o         = state_q;
    assign bubble_cnt      = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed, table-driven bench for fetch_sequencer, plus
// hand-written sequences for glitch, halt, asynchronous reset, predecode and
// bubble-counter saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall_i, redirect_i, halt_i;
    logic [7:0]  redirect_pc_i;
    logic [15:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic        ifid_valid, ifid_pred_taken, flush_idex_o;
    logic [1:0]  state_o;
    logic [15:0] bubble_cnt;

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .halt_i          (halt_i),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid),
        .ifid_pred_taken (ifid_pred_taken),
        .flush_idex_o    (flush_idex_o),
        .state_o         (state_o),
        .bubble_cnt      (bubble_cnt)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [7:0]  rpc;
        logic        flush;   // expected before the edge
        logic [7:0]  pc;      // expected after the edge
        logic [7:0]  ifid_pc;
        logic        valid;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [7:0] rpc, input logic fl,
                       input logic [7:0] pc, input logic [7:0] ipc, input logic v,
                       input logic [1:0] st, input logic [15:0] cnt);
        vec_t x;
        x.stall = s; x.redirect = r; x.rpc = rpc; x.flush = fl; x.pc = pc;
        x.ifid_pc = ipc; x.valid = v; x.st = st; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; redirect_pc_i = 8'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h3C, 8'(i)};
        idle_inputs();
        rst_n = 1'b0;

        //       s  r  rpc  fl pc   ipc  v  st cnt
        add(0, 0, 8'd0,   0, 8'd1,   8'd0,   1, 2'd0, 16'd0);
        add(0, 0, 8'd0,   0, 8'd2,   8'd1,   1, 2'd0, 16'd0);
        add(0, 0, 8'd0,   0, 8'd3,   8'd2,   1, 2'd0, 16'd0);
        add(0, 0, 8'd0,   0, 8'd4,   8'd3,   1, 2'd0, 16'd0);
        add(1, 0, 8'd0,   0, 8'd4,   8'd3,   1, 2'd1, 16'd0);
        add(1, 0, 8'd0,   0, 8'd4,   8'd3,   1, 2'd1, 16'd0);
        add(1, 0, 8'd0,   0, 8'd4,   8'd3,   1, 2'd1, 16'd0);
        add(0, 0, 8'd0,   0, 8'd5,   8'd4,   1, 2'd0, 16'd0);
        add(0, 0, 8'd0,   0, 8'd6,   8'd5,   1, 2'd0, 16'd0);
        add(1, 1, 8'd10,  1, 8'd10,  8'd0,   0, 2'd0, 16'd1);
        add(0, 0, 8'd0,   0, 8'd11,  8'd10,  1, 2'd0, 16'd1);
        add(0, 1, 8'd254, 1, 8'd254, 8'd0,   0, 2'd0, 16'd2);
        add(0, 0, 8'd0,   0, 8'd255, 8'd254, 1, 2'd0, 16'd2);
        add(0, 0, 8'd0,   0, 8'd0,   8'd255, 1, 2'd0, 16'd2);
        add(0, 0, 8'd0,   0, 8'd1,   8'd0,   1, 2'd0, 16'd2);
        add(1, 0, 8'd0,   0, 8'd1,   8'd0,   1, 2'd1, 16'd2);
        add(0, 1, 8'd7,   1, 8'd7,   8'd0,   0, 2'd0, 16'd3);
        add(0, 0, 8'd0,   0, 8'd8,   8'd7,   1, 2'd0, 16'd3);

        // Reset values, sampled while rst_n is low.
        #12;
        chk("rst_pc", imem_addr, 8'd0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_valid", ifid_valid, 1'b0);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_ifid_pc", ifid_pc, 8'd0);
        chk("rst_pred", ifid_pred_taken, 1'b0);
        chk("rst_cnt", bubble_cnt, 16'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            stall_i       = vecs[i].stall;
            redirect_i    = vecs[i].redirect;
            redirect_pc_i = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_flush", i), flush_idex_o, vecs[i].flush);
            edge_sample();
            chk($sformatf("v%0d_pc", i), imem_addr, vecs[i].pc);
            chk($sformatf("v%0d_valid", i), ifid_valid, vecs[i].valid);
            chk($sformatf("v%0d_state", i), state_o, vecs[i].st);
            chk($sformatf("v%0d_cnt", i), bubble_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_pred", i), ifid_pred_taken, 1'b0);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_ifid_pc", i), ifid_pc, vecs[i].ifid_pc);
                chk($sformatf("v%0d_instr", i), ifid_instr, mem[vecs[i].ifid_pc]);
            end else begin
                chk($sformatf("v%0d_instr", i), ifid_instr, 16'h0000);
            end
        end
        idle_inputs();

        // A stall pulse that ends before the edge must not be seen (pc=8 here).
        stall_i = 1'b1;
        #2;
        stall_i = 1'b0;
        edge_sample();
        chk("glitch_pc", imem_addr, 8'd9);
        chk("glitch_ifid_pc", ifid_pc, 8'd8);
        chk("glitch_state", state_o, 2'd0);

        // Halt for one cycle, then try to redirect/stall out of it.
        halt_i = 1'b1;
        #1;
        chk("halt_flush_pre", flush_idex_o, 1'b0);
        edge_sample();
        chk("halt_state", state_o, 2'd2);
        chk("halt_valid", ifid_valid, 1'b0);
        chk("halt_pc", imem_addr, 8'd9);
        chk("halt_cnt", bubble_cnt, 16'd4);
        halt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 8'd33; stall_i = 1'b1;
        #1;
        chk("halt_flush", flush_idex_o, 1'b0);
        edge_sample();
        chk("halt_hold_state", state_o, 2'd2);
        chk("halt_hold_pc", imem_addr, 8'd9);
        chk("halt_hold_valid", ifid_valid, 1'b0);
        idle_inputs();
        edge_sample();
        chk("halt_stay_state", state_o, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_pc", imem_addr, 8'd0);
        chk("halt_rst_state", state_o, 2'd0);
        chk("halt_rst_cnt", bubble_cnt, 16'd0);
        #2 rst_n = 1'b1;

        // Asynchronous reset out of STALL.
        edge_sample();
        chk("rs_pc", imem_addr, 8'd1);
        stall_i = 1'b1;
        edge_sample();
        chk("rs_state", state_o, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_rst_state", state_o, 2'd0);
        chk("rs_rst_pc", imem_addr, 8'd0);
        chk("rs_rst_valid", ifid_valid, 1'b0);
        stall_i = 1'b0;
        #2 rst_n = 1'b1;

        // Jump word at address 4.
        mem[4] = 16'b10101_000_00001010;
        repeat (4) edge_sample();
        chk("pd_pc_before", imem_addr, 8'd4);
        edge_sample();
        chk("pd_ifid_pc", ifid_pc, 8'd4);
        chk("pd_instr", ifid_instr, 16'hA80A);
        chk("pd_cnt", bubble_cnt, 16'd0);
        chk("pd_valid", ifid_valid, 1'b1);
`ifdef FETCH_PREDECODE_EN
        chk("pd_pred", ifid_pred_taken, 1'b1);
        chk("pd_pc", imem_addr, 8'd10);
        edge_sample();
        chk("pd_next_ifid_pc", ifid_pc, 8'd10);
`else
        chk("pd_pred", ifid_pred_taken, 1'b0);
        chk("pd_pc", imem_addr, 8'd5);
        edge_sample();
        chk("pd_next_ifid_pc", ifid_pc, 8'd5);
`endif
        chk("pd_next_pred", ifid_pred_taken, 1'b0);
        chk("pd_next_cnt", bubble_cnt, 16'd0);

        // Bubble counter saturation.
        redirect_i = 1'b1; redirect_pc_i = 8'd0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", bubble_cnt, 16'hFFFF);
        edge_sample();
        chk("sat_cnt_hold", bubble_cnt, 16'hFFFF);
        redirect_i = 1'b0;
        edge_sample();
        chk("sat_valid", ifid_valid, 1'b1);
        chk("sat_cnt_after", bubble_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
